// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: groups the two masters' request/response signals and the
// RAM / I-O side of the shared 8-bit bus into one bundle.
// The controller connects through the slave modport and the environment
// (masters, RAM, I/O port) through the master modport.
// Optional feature macro: MEM_BUS_LOCK_EN adds the per-master lock inputs.
interface mem_bus_ctrl_if;
    logic       m0_req, m1_req;
    logic       m0_we, m1_we;
    logic       m0_io, m1_io;
    logic [7:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
`ifdef MEM_BUS_LOCK_EN
    logic       m0_lock, m1_lock;
`endif
    logic       m0_gnt, m1_gnt;
    logic       m0_done, m1_done;
    logic [7:0] rdata;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we, ram_oe, mem_clk;
    logic [7:0] io_addr, io_wdata, io_rdata;
    logic       io_wr, io_rd;
    logic       busy;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_io, m1_io,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata,
`ifdef MEM_BUS_LOCK_EN
        input  m0_lock, m1_lock,
`endif
        input  ram_rdata, io_rdata,
        output m0_gnt, m1_gnt, m0_done, m1_done, rdata,
        output ram_addr, ram_wdata, ram_we, ram_oe, mem_clk,
        output io_addr, io_wdata, io_wr, io_rd, busy
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_io, m1_io,
        output m0_addr, m1_addr, m0_wdata, m1_wdata,
`ifdef MEM_BUS_LOCK_EN
        output m0_lock, m1_lock,
`endif
        output ram_rdata, io_rdata,
        input  m0_gnt, m1_gnt, m0_done, m1_done, rdata,
        input  ram_addr, ram_wdata, ram_we, ram_oe, mem_clk,
        input  io_addr, io_wdata, io_wr, io_rd, busy
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: round-robin arbiter and three-phase (SETUP/STROBE/DONE)
// sequencer for the shared 8-bit RAM / I-O bus with two masters.
// Optional feature macro: MEM_BUS_LOCK_EN -- the owning master may hold
// lock to be regranted directly from DONE (atomic read-modify-write).
// Every bus strobe is a register output so mem_clk cannot glitch.
module mem_bus_ctrl #(
    parameter logic [7:0] IO_IN_ADDR  = 8'h01,
    parameter logic [7:0] IO_OUT_ADDR = 8'h00
) (
    input logic           clk,
    input logic           reset,
    mem_bus_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t     state, state_next;
    logic       owner, owner_next;    // 0 = m0, 1 = m1
    logic       last, last_next;      // last master granted by arbitration
    logic       we_q, io_q, we_next, io_next;
    logic [7:0] addr_q, wdata_q, addr_next, wdata_next;
    logic       cand0, cand1, lock_hold, grant, win;
    logic       in_txn_next, ram_phase_next, strobe_next;

    logic       gnt0_q, gnt1_q, done0_q, done1_q;
    logic       ram_we_q, ram_oe_q, mem_clk_q, io_wr_q, io_rd_q;
    logic [7:0] rdata_q, ram_addr_q, ram_wdata_q, io_addr_q, io_wdata_q;

    // Read data source: RAM, the I/O input port, or open bus (8'hFF).
    function automatic logic [7:0] read_value(input logic io, input logic [7:0] addr,
                                              input logic [7:0] ram_in, input logic [7:0] io_in);
        if (!io)
            return ram_in;
        else if (addr == IO_IN_ADDR)
            return io_in;
        else
            return 8'hFF;
    endfunction

    // Arbitration, next state and the fields latched for the next transaction.
    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        we_next    = we_q;
        io_next    = io_q;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        cand0      = 1'b0;
        cand1      = 1'b0;
        lock_hold  = 1'b0;
        grant      = 1'b0;
        win        = 1'b0;

        if (state == IDLE || state == DONE) begin
            // The finishing master's own request is not considered in its DONE cycle.
            cand0 = bus.m0_req && !(state == DONE && owner == 1'b0);
            cand1 = bus.m1_req && !(state == DONE && owner == 1'b1);
`ifdef MEM_BUS_LOCK_EN
            if (state == DONE)
                lock_hold = owner ? (bus.m1_lock && bus.m1_req) : (bus.m0_lock && bus.m0_req);
`endif
            grant = cand0 || cand1 || lock_hold;
            if (lock_hold)
                win = owner;
            else if (cand0 && cand1)
                win = ~last;
            else
                win = cand1;
        end

        case (state)
            IDLE:    state_next = grant ? SETUP : IDLE;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = DONE;
            DONE:    state_next = grant ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase

        if (grant) begin
            owner_next = win;
            if (!lock_hold)
                last_next = win;
            we_next    = win ? bus.m1_we    : bus.m0_we;
            io_next    = win ? bus.m1_io    : bus.m0_io;
            addr_next  = win ? bus.m1_addr  : bus.m0_addr;
            wdata_next = win ? bus.m1_wdata : bus.m0_wdata;
        end

        in_txn_next    = (state_next != IDLE);
        ram_phase_next = (state_next == SETUP) || (state_next == STROBE);
        strobe_next    = (state_next == STROBE);
    end

    // State register, arbitration pointer and latched transaction fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            last    <= last_next;
            we_q    <= we_next;
            io_q    <= io_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
        end
    end

    // Registered grants, done pulses and bus strobes for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            ram_oe_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            mem_clk_q <= 1'b0;
            io_wr_q   <= 1'b0;
            io_rd_q   <= 1'b0;
        end else begin
            gnt0_q    <= in_txn_next && !owner_next;
            gnt1_q    <= in_txn_next && owner_next;
            done0_q   <= (state_next == DONE) && !owner_next;
            done1_q   <= (state_next == DONE) && owner_next;
            ram_oe_q  <= ram_phase_next && !io_next && !we_next;
            ram_we_q  <= ram_phase_next && !io_next && we_next;
            mem_clk_q <= strobe_next && !io_next;
            io_wr_q   <= strobe_next && io_next && we_next && (addr_next == IO_OUT_ADDR);
            io_rd_q   <= strobe_next && io_next && !we_next && (addr_next == IO_IN_ADDR);
        end
    end

    // Address/data outputs follow the granted transaction; read data is captured leaving STROBE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q  <= 8'h00;
            ram_wdata_q <= 8'h00;
            io_addr_q   <= 8'h00;
            io_wdata_q  <= 8'h00;
            rdata_q     <= 8'h00;
        end else begin
            if (grant) begin
                if (io_next) begin
                    io_addr_q  <= addr_next;
                    io_wdata_q <= wdata_next;
                end else begin
                    ram_addr_q  <= addr_next;
                    ram_wdata_q <= wdata_next;
                end
            end
            if (state == STROBE && !we_q)
                rdata_q <= read_value(io_q, addr_q, bus.ram_rdata, bus.io_rdata);
        end
    end

    assign bus.m0_gnt    = gnt0_q;
    assign bus.m1_gnt    = gnt1_q;
    assign bus.m0_done   = done0_q;
    assign bus.m1_done   = done1_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_oe    = ram_oe_q;
    assign bus.mem_clk   = mem_clk_q;
    assign bus.io_addr   = io_addr_q;
    assign bus.io_wdata  = io_wdata_q;
    assign bus.io_wr     = io_wr_q;
    assign bus.io_rd     = io_rd_q;
    assign bus.busy      = (state != IDLE);

endmodule
